// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, registered read data.
// Latency: rd_data updates on the edge that accepts rd_en; a write shows in count/empty one edge later.
// Backpressure: wr_en while full and rd_en while empty are ignored; caller watches full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    // No write-through-read when full: a pop in the same cycle does not free the slot early.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter, 8N1; define UART_TX_PARITY_EN for 8E1 (even parity bit after bit 7).
// Latency: byte pushed into an empty FIFO at edge E0 drives the start bit from edge E1; frames run back-to-back.
// Backpressure: tx_ready = !full; a push while full is dropped even if a pop happens that cycle.
module uart_tx_buffered #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    import uart_pkg::*;

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] byte_q;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 tx_q, tx_d;
    logic                 pop, full, empty, term;

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (tx_valid),
        .wr_data(tx_data),
        .rd_en  (pop),
        .rd_data(fifo_rd_data),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    assign tx_ready = !full;
    assign term     = (cnt_q == CNT_W'(CPB - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = term ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: if (term) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (term) begin
                if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (term) state_d = STOP;
`endif
            STOP: if (term) begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the state being entered so the registered pin lines up with the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_q[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^byte_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            // FIFO read data lands one edge after the pop; the start bit gives ample time to capture it.
            if (state_q == START) byte_q <= fifo_rd_data;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed frames, overflow, reset abort and random traffic,
// checked against a queue/timing model and a line-decoding receiver.
module tb_uart_tx_buffered;
    localparam int DEPTH = 4;
    localparam int BIT   = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * BIT;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_ready, tx, busy;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rst_cnt = 0;
    int lows;

    // Reference model: bytes waiting, and the edge at which the line is next free.
    byte unsigned pend[$];
    int           free_edge = 0;
    bit           m_room, m_pop;
    byte unsigned exp_b[$];
    int           exp_st[$];

    // Receiver side.
    byte unsigned rx_b[$];
    int           rx_st[$];
    bit           rx_fe[$];
    int           mon_st, mon_rc;
    logic [7:0]   mon_d;
    bit           mon_fe;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLK_HZ    (16),
        .BAUD      (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            pend.delete();
            exp_b.delete();
            exp_st.delete();
            free_edge = 0;
        end else begin
            m_room = (pend.size() < DEPTH);
            m_pop  = (pend.size() > 0) && (cyc >= free_edge);
            if (m_pop) begin
                exp_b.push_back(pend.pop_front());
                exp_st.push_back(cyc);
                free_edge = cyc + FRAME;
            end
            if (tx_valid && m_room) pend.push_back(tx_data);
        end
    end

    always @(negedge rst_n) rst_cnt++;

    // Samples mid-bit; frames overlapped by a reset are discarded.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            mon_st = cyc;
            mon_rc = rst_cnt;
            repeat (BIT / 2) @(negedge clk);
            mon_fe = (tx !== 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                mon_d[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (BIT) @(negedge clk);
            mon_fe |= (tx !== ^mon_d);
`endif
            repeat (BIT) @(negedge clk);
            mon_fe |= (tx !== 1'b1);
            if (mon_rc == rst_cnt) begin
                rx_b.push_back(mon_d);
                rx_st.push_back(mon_st);
                rx_fe.push_back(mon_fe);
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] b);
        @(negedge clk);
        check("tx_ready", tx_ready, pend.size() < DEPTH);
        check("fifo_count", fifo_count, pend.size());
        check("busy", busy, cyc < free_edge);
        tx_valid = v;
        tx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || fifo_count !== '0 || pend.size() != 0 || cyc < free_edge) && n < 3000) begin
            step(1'b0, 8'h00);
            n++;
        end
        check({tag, "_idle_timeout"}, n < 3000, 1);
        repeat (4) step(1'b0, 8'h00);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, rx_b.size(), exp_b.size());
        for (int i = 0; i < rx_b.size() && i < exp_b.size(); i++) begin
            check({tag, "_byte"}, rx_b[i], exp_b[i]);
            check({tag, "_start"}, rx_st[i], exp_st[i]);
            check({tag, "_frame_err"}, rx_fe[i], 0);
        end
        rx_b.delete();
        rx_st.delete();
        rx_fe.delete();
        exp_b.delete();
        exp_st.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 8'h00);

        // Single frame: exact latency and every bit held BIT cycles.
        step(1'b1, 8'h55);
        tx_valid = 1'b0;
        check("t1_e0_tx", tx, 1);
        check("t1_e0_count", fifo_count, 1);
        @(posedge clk);
        #1;
        check("t1_e1_busy", busy, 1);
        check("t1_e1_count", fifo_count, 0);
        for (int j = 0; j < FB; j++) begin
            check("t1_bit_first", tx, fbit(8'h55, j));
            repeat (BIT - 1) @(posedge clk);
            #1;
            check("t1_bit_last", tx, fbit(8'h55, j));
            check("t1_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        check("t1_done_busy", busy, 0);
        check("t1_done_tx", tx, 1);
        wait_idle("t1");
        check_frames("t1");

        // Back-to-back frames with no idle gap.
        step(1'b1, 8'h41);
        step(1'b1, 8'h42);
        step(1'b1, 8'h43);
        tx_valid = 1'b0;
        wait_idle("t2");
        check("t2_frames", rx_b.size(), 3);
        for (int i = 1; i < 3 && i < rx_st.size(); i++) check("t2_gap", rx_st[i] - rx_st[i-1], FRAME);
        check_frames("t2");

        // Overflow: tx_valid held for 6 bytes, only 5 fit (one in the shifter, four queued).
        for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + i[7:0]);
        check("t3_full_ready", tx_ready, 0);
        check("t3_full_count", fifo_count, DEPTH);
        tx_valid = 1'b0;
        wait_idle("t3");
        check("t3_frames", rx_b.size(), 5);
        for (int i = 0; i < 5 && i < rx_b.size(); i++) check("t3_byte", rx_b[i], 8'h60 + i);
        check_frames("t3");

        // Reset during data bit 1 of 0xA5 (a zero) with one byte still queued.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        tx_valid = 1'b0;
        repeat (BIT * 2 + 5) @(posedge clk);
        @(negedge clk);
        check("t4_pre_tx", tx, 0);
        check("t4_pre_busy", busy, 1);
        check("t4_pre_count", fifo_count, 1);
        rst_n = 1'b0;
        #1;
        check("t4_tx", tx, 1);
        check("t4_busy", busy, 0);
        check("t4_count", fifo_count, 0);
        check("t4_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < FRAME * 3; k++) begin
            step(1'b0, 8'h00);
            if (tx !== 1'b1) lows++;
        end
        check("t4_line_quiet", lows, 0);
        check("t4_no_frames", rx_b.size(), 0);
        check_frames("t4");

        // Random pushes and idle gaps against the model.
        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, FRAME + 20)) step(1'b0, 8'h00);
            end else begin
                step(1'b1, 8'($urandom));
            end
        end
        wait_idle("t5");
        check_frames("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
